dadda_dot_accumulator: RTL and testbench



---
 rtl/dadda_dot_accumulator_if.sv | 27 ++
 rtl/dadda_dot_accumulator.sv | 167 ++++++++++++++++
 tb/tb_dadda_dot_accumulator.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dadda_dot_accumulator_if.sv
// Product stream from the Dadda multiplier plus the valid/ready result handshake
// toward the downstream consumer.
interface dadda_dot_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
);
  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic              prod_last;
  logic [ACC_W-1:0]  res_data;
  logic [CNT_W-1:0]  res_count;
  logic              res_sat;
  logic              res_valid;
  logic              res_ready;
  logic              drop_err;

  modport master (
    output prod, prod_valid, prod_last, res_ready,
    input  res_data, res_count, res_sat, res_valid, drop_err
  );

  modport slave (
    input  prod, prod_valid, prod_last, res_ready,
    output res_data, res_count, res_sat, res_valid, drop_err
  );
endinterface

// File: rtl/dadda_dot_accumulator.sv
// Saturating dot-product accumulator over framed multiplier products, with a
// 2-entry result buffer whose head is held in the output registers.
module dadda_dot_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  dadda_dot_accumulator_if.slave  bus
);

  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             sat;
  } result_t;

  localparam result_t RESULT_ZERO = '{data: ACC_ZERO, count: CNT_ZERO, sat: 1'b0};

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;

  logic [ACC_W:0]   sum_ext_s;
  result_t          beat_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;

  fifo_state_e      state_r;
  fifo_state_e      state_next_s;
  result_t          head_r;
  result_t          head_next_s;
  result_t          tail_r;
  result_t          tail_next_s;
  logic             res_valid_r;
  logic             drop_err_r;

  // Running frame value including the current beat; the extra bit catches overflow.
  always_comb begin
    sum_ext_s    = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod};
    beat_s       = RESULT_ZERO;
    if (sum_ext_s[ACC_W]) begin
      beat_s.data = ACC_MAX;
      beat_s.sat  = 1'b1;
    end else begin
      beat_s.data = sum_ext_s[ACC_W-1:0];
      beat_s.sat  = sat_r;
    end
    if (cnt_r == CNT_MAX) begin
      beat_s.count = CNT_MAX;
    end else begin
      beat_s.count = cnt_r + CNT_ONE;
    end
  end

  assign push_s = bus.prod_valid & bus.prod_last;
  assign pop_s  = res_valid_r & bus.res_ready;

  // Accumulator: advance on every beat, restart on the frame's last beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r <= ACC_ZERO;
      cnt_r <= CNT_ZERO;
      sat_r <= 1'b0;
    end else if (bus.prod_valid && bus.prod_last) begin
      acc_r <= ACC_ZERO;
      cnt_r <= CNT_ZERO;
      sat_r <= 1'b0;
    end else if (bus.prod_valid) begin
      acc_r <= beat_s.data;
      cnt_r <= beat_s.count;
      sat_r <= beat_s.sat;
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
      sat_r <= sat_r;
    end
  end

  // Buffer occupancy and entry movement; the head register only changes when
  // a new entry becomes head, so it holds its last value once emptied.
  always_comb begin
    state_next_s = state_r;
    head_next_s  = head_r;
    tail_next_s  = tail_r;
    drop_s       = 1'b0;
    case (state_r)
      FIFO_EMPTY: begin
        if (push_s) begin
          head_next_s  = beat_s;
          state_next_s = FIFO_ONE;
        end else begin
          state_next_s = FIFO_EMPTY;
        end
      end
      FIFO_ONE: begin
        if (push_s && pop_s) begin
          head_next_s  = beat_s;
          state_next_s = FIFO_ONE;
        end else if (push_s) begin
          tail_next_s  = beat_s;
          state_next_s = FIFO_FULL;
        end else if (pop_s) begin
          state_next_s = FIFO_EMPTY;
        end else begin
          state_next_s = FIFO_ONE;
        end
      end
      FIFO_FULL: begin
        if (push_s && pop_s) begin
          head_next_s  = tail_r;
          tail_next_s  = beat_s;
          state_next_s = FIFO_FULL;
        end else if (pop_s) begin
          head_next_s  = tail_r;
          state_next_s = FIFO_ONE;
        end else if (push_s) begin
          drop_s       = 1'b1;
          state_next_s = FIFO_FULL;
        end else begin
          state_next_s = FIFO_FULL;
        end
      end
      default: begin
        state_next_s = FIFO_EMPTY;
      end
    endcase
  end

  // Buffer state and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= FIFO_EMPTY;
      head_r      <= RESULT_ZERO;
      tail_r      <= RESULT_ZERO;
      res_valid_r <= 1'b0;
      drop_err_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      head_r      <= head_next_s;
      tail_r      <= tail_next_s;
      res_valid_r <= (state_next_s != FIFO_EMPTY);
      drop_err_r  <= drop_err_r | drop_s;
    end
  end

  assign bus.res_data  = head_r.data;
  assign bus.res_count = head_r.count;
  assign bus.res_sat   = head_r.sat;
  assign bus.res_valid = res_valid_r;
  assign bus.drop_err  = drop_err_r;

endmodule

// File: tb/tb_dadda_dot_accumulator.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic against a frame-level reference model.
module tb_dadda_dot_accumulator;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;
  localparam longint ACC_MAX = 64'd16777215;

  logic clk;
  logic rst;

  dadda_dot_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  dadda_dot_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic [7:0]  count;
    logic        sat;
  } res_t;

  typedef struct {
    logic        r, v, l;
    logic [15:0] p;
    logic        rdy;
    logic        ev;
    logic [23:0] ed;
    logic [7:0]  ec;
    logic        es;
    logic        edr;
  } vec_t;

  // Reference model state: finished results waiting, last head shown, open frame.
  res_t   mq[$];
  res_t   shown;
  longint m_sum;
  int     m_n;
  logic   m_drop;

  int tests;
  int fails;
  vec_t tbl[16];

  function automatic vec_t mk(input logic r, v, l, input logic [15:0] p, input logic rdy,
                              input logic ev, input logic [23:0] ed, input logic [7:0] ec,
                              input logic es, input logic edr);
    vec_t t;
    t.r = r; t.v = v; t.l = l; t.p = p; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.ec = ec; t.es = es; t.edr = edr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level behaviour: the sum clamps at the maximum, the term count clamps at 255.
  task automatic model_edge(input logic r, v, l, input logic [15:0] p, input logic rdy);
    res_t nr;
    bit   pop;
    bit   full;
    if (!r) begin
      mq.delete();
      shown  = '{24'd0, 8'd0, 1'b0};
      m_sum  = 0;
      m_n    = 0;
      m_drop = 1'b0;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      full = (mq.size() == 2);
      if (pop) void'(mq.pop_front());
      if (v) begin
        m_sum += longint'(p);
        m_n++;
        if (l) begin
          nr.data  = (m_sum > ACC_MAX) ? 24'hFFFFFF : m_sum[23:0];
          nr.count = (m_n > 255) ? 8'd255 : m_n[7:0];
          nr.sat   = (m_sum > ACC_MAX);
          if (!full || pop) mq.push_back(nr);
          else m_drop = 1'b1;
          m_sum = 0;
          m_n   = 0;
        end
      end
      if (mq.size() != 0) shown = mq[0];
    end
  endtask

  // Drive one cycle's inputs, advance the model, and land on the next falling edge.
  task automatic step(input logic r, v, l, input logic [15:0] p, input logic rdy);
    rst            = r;
    bus.prod_valid = v;
    bus.prod_last  = l;
    bus.prod       = p;
    bus.res_ready  = rdy;
    model_edge(r, v, l, p, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [23:0] ed,
                         input logic [7:0] ec, input logic es, input logic edr);
    chk({tag, ".valid"}, {31'd0, bus.res_valid}, {31'd0, ev});
    chk({tag, ".data"},  {8'd0, bus.res_data},   {8'd0, ed});
    chk({tag, ".count"}, {24'd0, bus.res_count}, {24'd0, ec});
    chk({tag, ".sat"},   {31'd0, bus.res_sat},   {31'd0, es});
    chk({tag, ".drop"},  {31'd0, bus.drop_err},  {31'd0, edr});
  endtask

  task automatic chk_model(input string tag);
    chk_out(tag, (mq.size() != 0), shown.data, shown.count, shown.sat, m_drop);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.prod = 16'd0;
    bus.prod_valid = 1'b0;
    bus.prod_last = 1'b0;
    bus.res_ready = 1'b0;

    //           r     v     l     prod       rdy   valid data        cnt    sat   drop
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 16'd0,   1'b1, 1'b0, 24'd0,   8'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 16'd100, 1'b1, 1'b0, 24'd0,   8'd0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 16'd200, 1'b1, 1'b0, 24'd0,   8'd0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 16'd300, 1'b1, 1'b1, 24'd600, 8'd3, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 1'b0, 24'd600, 8'd3, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b1, 16'd7,   1'b1, 1'b1, 24'd7,   8'd1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 16'd9,   1'b1, 1'b1, 24'd9,   8'd1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 16'd11,  1'b1, 1'b1, 24'd11,  8'd1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 1'b0, 24'd11,  8'd1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b1, 1'b1, 16'd5,   1'b0, 1'b1, 24'd5,   8'd1, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 1'b1, 16'd6,   1'b0, 1'b1, 24'd5,   8'd1, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 16'd7,   1'b0, 1'b1, 24'd5,   8'd1, 1'b0, 1'b1);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 1'b1, 24'd6,   8'd1, 1'b0, 1'b1);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 1'b0, 24'd6,   8'd1, 1'b0, 1'b1);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 1'b0, 24'd6,   8'd1, 1'b0, 1'b1);
    tbl[15] = mk(1'b0, 1'b1, 1'b1, 16'd99,  1'b1, 1'b0, 24'd0,   8'd0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].p, tbl[i].rdy);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].es, tbl[i].edr);
    end

    // Saturation: 257 full-scale beats, then a small frame clears the flag.
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    chk_out("sat_open", 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    chk_out("sat_frame", 1'b1, 24'hFFFFFF, 8'd255, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h0002, 1'b1);
    chk_out("sat_next", 1'b1, 24'd2, 8'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    chk_out("sat_drain", 1'b0, 24'd2, 8'd1, 1'b0, 1'b0);

    // Full buffer with a push landing on the pop edge.
    step(1'b1, 1'b1, 1'b1, 16'd5, 1'b0);
    chk_out("fp_5", 1'b1, 24'd5, 8'd1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'd6, 1'b0);
    chk_out("fp_full", 1'b1, 24'd5, 8'd1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'd8, 1'b1);
    chk_out("fp_6", 1'b1, 24'd6, 8'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    chk_out("fp_8", 1'b1, 24'd8, 8'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    chk_out("fp_empty", 1'b0, 24'd8, 8'd1, 1'b0, 1'b0);

    // Reset mid-frame with a stored result and a sticky drop pending.
    step(1'b1, 1'b1, 1'b1, 16'd1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'd2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'd4, 1'b0);
    chk_out("rm_drop", 1'b1, 24'd1, 8'd1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'd40, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'd50, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'd77, 1'b1);
    chk_out("rm_reset", 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'd3, 1'b1);
    chk_out("rm_after", 1'b1, 24'd3, 8'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    chk_model("rm_model");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic        r, v, l, rdy;
      logic [15:0] p;
      r   = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 9) < 7);
      l   = ($urandom_range(0, 3) == 0);
      p   = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 15))
                                        : 16'($urandom);
      rdy = ($urandom_range(0, 9) < 6);
      step(r, v, l, p, rdy);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
